tree_merge_arb: RTL and testbench

TREE_MERGE_ARB -- requirements
Module: tree_merge_arb

---
 rtl/tree_merge_arb.sv | 99 +++++++++
 tb/tb_tree_merge_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_merge_arb.sv
// Two-input merge node: picks one of two packet streams into a single
// output register, alternating on contention, and counts grants per port.
module tree_merge_arb #(
  parameter int AddressWidth = 2,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 35
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] i_data_l,
  input  logic                  i_data_valid_l,
  output logic                  o_data_ready_l,
  input  logic [TotalWidth-1:0] i_data_r,
  input  logic                  i_data_valid_r,
  output logic                  o_data_ready_r,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [15:0]           o_grant_cnt_l,
  output logic [15:0]           o_grant_cnt_r
);

  if (TotalWidth < AddressWidth + DataWidth) begin : g_width_chk
    $error("TotalWidth too small for address and data fields");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TotalWidth-1:0] r_data;
  logic                  r_last_r;
  logic [15:0]           r_cnt_l;
  logic [15:0]           r_cnt_r;

  logic w_slot_free;
  logic w_win_l;
  logic w_win_r;
  logic w_rdy_l;
  logic w_rdy_r;
  logic w_accept;

  // Arbitration and handshake: tie goes to the port not granted last
  always_comb begin
    w_slot_free = (r_state == EMPTY) | i_data_ready;
    w_win_l = i_data_valid_l & (~i_data_valid_r | r_last_r);
    w_win_r = i_data_valid_r & (~i_data_valid_l | ~r_last_r);
    w_rdy_l = w_slot_free & w_win_l & ~rst;
    w_rdy_r = w_slot_free & w_win_r & ~rst;
    w_accept = w_rdy_l | w_rdy_r;
  end

  // Next state of the output slot
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) w_state_nxt = FULL;
      end
      FULL: begin
        if (w_accept) w_state_nxt = FULL;
        else if (i_data_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Output slot state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Capture winner packet, remember the grant and count it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_last_r <= 1'b1;
      r_cnt_l  <= '0;
      r_cnt_r  <= '0;
    end else if (w_accept) begin
      r_data   <= w_rdy_l ? i_data_l : i_data_r;
      r_last_r <= w_rdy_r;
      if (w_rdy_l) r_cnt_l <= r_cnt_l + 16'd1;
      if (w_rdy_r) r_cnt_r <= r_cnt_r + 16'd1;
    end
  end

  assign o_data_ready_l = w_rdy_l;
  assign o_data_ready_r = w_rdy_r;
  assign o_data         = r_data;
  assign o_data_valid   = (r_state == FULL);
  assign o_grant_cnt_l  = r_cnt_l;
  assign o_grant_cnt_r  = r_cnt_r;

endmodule

// File: tb/tb_tree_merge_arb.sv
// Bench for tree_merge_arb: directed scenarios with literal expectations
// plus a cycle model and per-port order scoreboard under random traffic.
module tb_tree_merge_arb;

  localparam int TW = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] dl = '0;
  logic          vl = 1'b0;
  logic          rl;
  logic [TW-1:0] dr = '0;
  logic          vr = 1'b0;
  logic          rr;
  logic [TW-1:0] od;
  logic          ov;
  logic          rdy = 1'b0;
  logic [15:0]   cl;
  logic [15:0]   cr;

  always #5 clk = ~clk;

  tree_merge_arb #(
    .AddressWidth(2),
    .DataWidth(32),
    .TotalWidth(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data_l(dl),
    .i_data_valid_l(vl),
    .o_data_ready_l(rl),
    .i_data_r(dr),
    .i_data_valid_r(vr),
    .o_data_ready_r(rr),
    .o_data(od),
    .o_data_valid(ov),
    .i_data_ready(rdy),
    .o_grant_cnt_l(cl),
    .o_grant_cnt_r(cr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [TW-1:0] act,
                     input logic [TW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: one holding slot, alternating tie-break
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_data = '0;
  logic          m_last_r = 1'b1;
  logic [15:0]   m_cl = '0;
  logic [15:0]   m_cr = '0;
  int            sent_l = 0;
  int            sent_r = 0;
  int            acc_l = 0;
  int            acc_r = 0;
  logic          sb_en = 1'b0;
  logic          e_l;
  logic          e_r;
  logic          room;
  logic          pick_l;
  logic          pick_r;

  always_comb begin
    room = !m_valid || rdy;
    pick_l = 1'b0;
    pick_r = 1'b0;
    if (vl && vr) begin
      if (m_last_r) pick_l = 1'b1;
      else pick_r = 1'b1;
    end else if (vl) begin
      pick_l = 1'b1;
    end else if (vr) begin
      pick_r = 1'b1;
    end
    e_l = !rst && room && pick_l;
    e_r = !rst && room && pick_r;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last_r <= 1'b1;
      m_cl <= '0;
      m_cr <= '0;
    end else if (e_l || e_r) begin
      m_valid <= 1'b1;
      m_data <= e_l ? dl : dr;
      m_last_r <= e_r;
      if (e_l) begin
        m_cl <= m_cl + 16'd1;
        sent_l <= sent_l + 1;
        if (sb_en) acc_l <= acc_l + 1;
      end else begin
        m_cr <= m_cr + 16'd1;
        sent_r <= sent_r + 1;
        if (sb_en) acc_r <= acc_r + 1;
      end
    end else if (rdy) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: every cycle, mid-period
  int          out_l = 0;
  int          out_r = 0;
  logic        seen_l = 1'b0;
  logic        seen_r = 1'b0;
  logic [31:0] last_l = '0;
  logic [31:0] last_r = '0;

  always @(negedge clk) begin
    chk("rdy_l", TW'(rl), TW'(e_l));
    chk("rdy_r", TW'(rr), TW'(e_r));
    chk("valid", TW'(ov), TW'(m_valid));
    if (m_valid) chk("data", od, m_data);
    chk("cnt_l", TW'(cl), TW'(m_cl));
    chk("cnt_r", TW'(cr), TW'(m_cr));
    if (!sb_en) begin
      seen_l = 1'b0;
      seen_r = 1'b0;
    end else if (ov && rdy && !rst) begin
      if (od[32] == 1'b0) begin
        if (seen_l) chk("sb_order_l", TW'(od[31:0]), TW'(last_l + 32'd1));
        last_l = od[31:0];
        seen_l = 1'b1;
        out_l++;
      end else begin
        if (seen_r) chk("sb_order_r", TW'(od[31:0]), TW'(last_r + 32'd1));
        last_r = od[31:0];
        seen_r = 1'b1;
        out_r++;
      end
    end
  end

  logic auto_l = 1'b0;
  logic auto_r = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_l) dl = {3'b000, 32'(sent_l + 1)};
    if (auto_r) dr = {3'b001, 32'(sent_r + 1)};
  endtask

  initial begin
    // Reset state, with both requesters pushing
    vl = 1'b1;
    vr = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", TW'(ov), '0);
    chk("rst_data", od, '0);
    chk("rst_rdy_l", TW'(rl), '0);
    chk("rst_rdy_r", TW'(rr), '0);
    chk("rst_cnt_l", TW'(cl), '0);
    chk("rst_cnt_r", TW'(cr), '0);

    // Alternating service under full contention
    tick();
    rst = 1'b0;
    auto_l = 1'b1;
    auto_r = 1'b1;
    dl = {3'b000, 32'(sent_l + 1)};
    dr = {3'b001, 32'(sent_r + 1)};
    tick();
    @(negedge clk);
    chk("alt_first_l", od, 35'h0_00000001);
    tick();
    @(negedge clk);
    chk("alt_then_r", od, 35'h1_00000001);
    repeat (8) tick();
    @(negedge clk);
    chk("alt_cnt_l5", TW'(cl), TW'(16'd5));
    chk("alt_cnt_r5", TW'(cr), TW'(16'd5));

    // Single requester, then right wins the first tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vl = 1'b1;
    vr = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("solo_cnt_l4", TW'(cl), TW'(16'd4));
    chk("solo_cnt_r0", TW'(cr), '0);
    #1;
    vr = 1'b1;
    #1;
    chk("tie_rdy_r", TW'(rr), TW'(1'b1));
    chk("tie_rdy_l", TW'(rl), '0);

    // Stall holds the packet, then the next one follows
    tick();
    auto_l = 1'b0;
    auto_r = 1'b0;
    dl = 35'h2_000000AA;
    vl = 1'b1;
    vr = 1'b0;
    rdy = 1'b1;
    tick();
    dl = 35'h2_000000BB;
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data", od, 35'h2_000000AA);
      chk("stall_valid", TW'(ov), TW'(1'b1));
      chk("stall_rdy_l", TW'(rl), '0);
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("unstall_rdy_l", TW'(rl), TW'(1'b1));
    tick();
    @(negedge clk);
    chk("unstall_data", od, 35'h2_000000BB);

    // Reset while full and stalled
    rdy = 1'b0;
    vr = 1'b1;
    dr = 35'h1_00000077;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy_l", TW'(rl), '0);
    chk("midrst_rdy_r", TW'(rr), '0);
    tick();
    @(negedge clk);
    chk("midrst_valid", TW'(ov), '0);
    chk("midrst_cnt_l", TW'(cl), '0);
    chk("midrst_cnt_r", TW'(cr), '0);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_l_first", TW'(rl), TW'(1'b1));

    // Left counter wraps after 65536 grants
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_l = 1'b1;
    vl = 1'b1;
    vr = 1'b0;
    rdy = 1'b1;
    dl = {3'b000, 32'(sent_l + 1)};
    repeat (65535) tick();
    @(negedge clk);
    chk("wrap_ffff", TW'(cl), TW'(16'hFFFF));
    tick();
    @(negedge clk);
    chk("wrap_zero", TW'(cl), '0);

    // Random traffic with order scoreboard
    rst = 1'b1;
    vl = 1'b0;
    tick();
    sb_en = 1'b1;
    auto_r = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10000) begin
      vl = 1'($urandom_range(0, 1));
      vr = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    vl = 1'b0;
    vr = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    chk("sb_count_l", TW'(out_l), TW'(acc_l));
    chk("sb_count_r", TW'(out_r), TW'(acc_r));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
